// File: rtl/sdram_responder_if.sv
// rtl/sdram_responder_if.sv - SDRAM command/control pins as driven by the controller
// and sampled by the responder.
interface sdram_responder_if;
  logic        sd_cke;
  logic        sd_cs;
  logic        sd_ras;
  logic        sd_cas;
  logic        sd_we;
  logic [1:0]  sd_ba;
  logic [10:0] sd_addr;
  logic [3:0]  sd_dqm;

  modport master (output sd_cke, sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm);
  modport slave  (input  sd_cke, sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm);
endinterface

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - checking SDR SDRAM responder: bank/mode tracking, CL read pipe,
// violation capture. Optional macro SDRAM_RESP_INIT_CHECK_EN flags accesses before init.
module sdram_responder #(
  parameter int MEM_AW = 14,
  parameter int TRCD   = 2,
  parameter int TRFC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  sdram_responder_if.slave sd,
  inout  wire  [31:0]      sd_data,
  output logic             init_done,
  output logic             error,
  output logic [2:0]       error_code,
  output logic [15:0]      refresh_cnt
);
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_BT  = 3'b110;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  typedef enum logic [1:0] {BANK_IDLE, BANK_ACT, BANK_AUTOPRE} bank_t;
  typedef enum logic [1:0] {INIT_WAIT_PRE, INIT_WAIT_MODE, INIT_DONE} init_t;

  logic [2:0]        cmd;
  logic [1:0]        ba;
  logic [10:0]       addr;
  logic              cmd_sel;
  logic              busy;
  logic              exec;

  bank_t             bank_st  [4];
  logic [10:0]       bank_row [4];
  logic [7:0]        trcd_cnt [4];
  logic [3:0]        ap_cnt   [4];
  logic [3:0]        bank_idle;
  logic              all_idle;

  logic [1:0]        mode_bl;
  logic              mode_cl3;
  logic              mode_sw;
  logic              mode_ok;
  logic              mode_load;
  logic [7:0]        rfc_cnt;

  init_t             init_st;
  init_t             init_nx;
  logic              pre_init;

  logic              bst_active;
  logic              bst_read;
  logic [1:0]        bst_ba;
  logic [10:0]       bst_row;
  logic [7:0]        bst_col;
  logic [2:0]        bst_mask;
  logic [2:0]        bst_k;
  logic [2:0]        bst_left;

  logic              acc_new;
  logic              beat_go;
  logic              b_read;
  logic [1:0]        b_ba;
  logic [10:0]       b_row;
  logic [7:0]        b_col;
  logic [2:0]        b_mask;
  logic [2:0]        b_k;
  logic [2:0]        acc_mask;
  logic [MEM_AW-1:0] b_idx;

  logic [31:0]       mem [2**MEM_AW];
  logic [1:0]        pipe_v;
  logic [31:0]       pipe_d [2];
  logic [31:0]       out_d;
  logic [3:0]        out_oe;
  logic [3:0]        dqm_d1;

  logic [7:0]        err_v;
  logic [2:0]        err_first;

  function automatic logic [2:0] bl_mask(input logic [1:0] code);
    case (code)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  assign cmd      = {sd.sd_ras, sd.sd_cas, sd.sd_we};
  assign ba       = sd.sd_ba;
  assign addr     = sd.sd_addr;
  assign cmd_sel  = sd.sd_cke && !sd.sd_cs && (cmd != CMD_NOP);
  assign busy     = (rfc_cnt != 8'd0);
  assign exec     = cmd_sel && !busy;
  assign mode_ok  = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && !addr[3] && !addr[2];
  assign acc_mask = ((cmd == CMD_WR) && mode_sw) ? 3'd0 : bl_mask(mode_bl);

`ifdef SDRAM_RESP_INIT_CHECK_EN
  assign pre_init = !init_done;
`else
  assign pre_init = 1'b0;
`endif

  // An auto-precharging bank whose count expires on this edge already counts as idle.
  always_comb begin
    bank_idle = '0;
    for (int b = 0; b < 4; b++)
      bank_idle[b] = (bank_st[b] == BANK_IDLE) ||
                     ((bank_st[b] == BANK_AUTOPRE) && (ap_cnt[b] <= 4'd1));
  end
  assign all_idle  = &bank_idle;
  assign mode_load = exec && (cmd == CMD_LMR) && mode_ok && all_idle;

  always_ff @(posedge clk) begin
    if (reset) init_st <= INIT_WAIT_PRE;
    else       init_st <= init_nx;
  end

  always_comb begin
    init_nx = init_st;
    case (init_st)
      INIT_WAIT_PRE:  if (exec && (cmd == CMD_PRE) && addr[10]) init_nx = INIT_WAIT_MODE;
      INIT_WAIT_MODE: if (mode_load) init_nx = INIT_DONE;
      default:        init_nx = init_st;
    endcase
  end

  always_comb begin
    init_done = (init_st == INIT_DONE);
  end

  // A new access replaces any running burst; otherwise the latched burst supplies the beat.
  always_comb begin
    acc_new = exec && ((cmd == CMD_RD) || (cmd == CMD_WR));
    beat_go = acc_new || (sd.sd_cke && bst_active && !(exec && (cmd == CMD_BT)));
    b_read  = bst_read;
    b_ba    = bst_ba;
    b_row   = bst_row;
    b_col   = bst_col;
    b_mask  = bst_mask;
    b_k     = bst_k;
    if (acc_new) begin
      b_read = (cmd == CMD_RD);
      b_ba   = ba;
      b_row  = bank_row[ba];
      b_col  = addr[7:0];
      b_mask = acc_mask;
      b_k    = 3'd0;
    end
    b_idx = MEM_AW'({b_ba, b_row, b_col[7:3],
                     (b_col[2:0] & ~b_mask) | ((b_col[2:0] + b_k) & b_mask)});
  end

  always_comb begin
    err_v = '0;
    if (cmd_sel && busy) err_v[7] = 1'b1;
    if (exec) begin
      case (cmd)
        CMD_ACT: err_v[1] = !bank_idle[ba];
        CMD_RD, CMD_WR: begin
          err_v[2] = (bank_st[ba] != BANK_ACT);
          err_v[3] = (bank_st[ba] == BANK_ACT) && (trcd_cnt[ba] != 8'd0);
        end
        CMD_LMR: begin
          err_v[4] = !mode_ok;
          err_v[5] = !all_idle;
        end
        CMD_REF: err_v[6] = !all_idle;
        default: err_v = err_v;
      endcase
      err_v[0] = pre_init && ((cmd == CMD_ACT) || (cmd == CMD_RD) ||
                              (cmd == CMD_WR)  || (cmd == CMD_REF));
    end
    err_first = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (err_v[i]) err_first = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_bl     <= 2'd0;
      mode_cl3    <= 1'b0;
      mode_sw     <= 1'b0;
      rfc_cnt     <= 8'd0;
      refresh_cnt <= 16'd0;
      error       <= 1'b0;
      error_code  <= 3'd0;
      bst_active  <= 1'b0;
      bst_read    <= 1'b0;
      bst_ba      <= 2'd0;
      bst_row     <= 11'd0;
      bst_col     <= 8'd0;
      bst_mask    <= 3'd0;
      bst_k       <= 3'd0;
      bst_left    <= 3'd0;
      for (int b = 0; b < 4; b++) begin
        bank_st[b]  <= BANK_IDLE;
        bank_row[b] <= 11'd0;
        trcd_cnt[b] <= 8'd0;
        ap_cnt[b]   <= 4'd0;
      end
    end else if (sd.sd_cke) begin
      if (mode_load) begin
        mode_bl  <= addr[1:0];
        mode_cl3 <= (addr[6:4] == 3'd3);
        mode_sw  <= addr[9];
      end

      if (exec && (cmd == CMD_REF)) begin
        refresh_cnt <= refresh_cnt + 16'd1;
        rfc_cnt     <= 8'(TRFC);
      end else if (busy) begin
        rfc_cnt <= rfc_cnt - 8'd1;
      end

      if (!error && (err_v != 8'd0)) begin
        error      <= 1'b1;
        error_code <= err_first;
      end

      if (acc_new) begin
        bst_active <= (acc_mask != 3'd0);
        bst_read   <= (cmd == CMD_RD);
        bst_ba     <= ba;
        bst_row    <= bank_row[ba];
        bst_col    <= addr[7:0];
        bst_mask   <= acc_mask;
        bst_k      <= 3'd1;
        bst_left   <= acc_mask;
      end else if (bst_active) begin
        if (exec && (cmd == CMD_BT)) begin
          bst_active <= 1'b0;
        end else begin
          bst_k    <= bst_k + 3'd1;
          bst_left <= bst_left - 3'd1;
          if (bst_left == 3'd1) bst_active <= 1'b0;
        end
      end

      for (int b = 0; b < 4; b++) begin
        if (trcd_cnt[b] != 8'd0) trcd_cnt[b] <= trcd_cnt[b] - 8'd1;
        if (bank_st[b] == BANK_AUTOPRE) begin
          if (ap_cnt[b] <= 4'd1) bank_st[b] <= BANK_IDLE;
          else                   ap_cnt[b]  <= ap_cnt[b] - 4'd1;
        end
        if (exec) begin
          case (cmd)
            CMD_ACT: if ((ba == 2'(b)) && bank_idle[b]) begin
              bank_st[b]  <= BANK_ACT;
              bank_row[b] <= addr;
              trcd_cnt[b] <= 8'(TRCD - 1);
            end
            CMD_PRE: if (addr[10] || (ba == 2'(b))) bank_st[b] <= BANK_IDLE;
            CMD_RD, CMD_WR: if ((ba == 2'(b)) && addr[10] && (bank_st[b] == BANK_ACT)) begin
              bank_st[b] <= BANK_AUTOPRE;
              ap_cnt[b]  <= {1'b0, acc_mask} + 4'd1;
            end
            default: bank_st[b] <= bank_st[b];
          endcase
        end
      end
    end
  end

  // Read beats enter at depth CL-1 so they reach the bus register one edge before validity.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v    <= 2'b00;
      pipe_d[0] <= 32'd0;
      pipe_d[1] <= 32'd0;
      out_d     <= 32'd0;
      out_oe    <= 4'h0;
      dqm_d1    <= 4'h0;
    end else if (sd.sd_cke) begin
      dqm_d1    <= sd.sd_dqm;
      out_d     <= pipe_d[0];
      out_oe    <= pipe_v[0] ? ~dqm_d1 : 4'h0;
      pipe_v    <= {1'b0, pipe_v[1]};
      pipe_d[0] <= pipe_d[1];
      if (beat_go && b_read) begin
        if (mode_cl3) begin
          pipe_v[1] <= 1'b1;
          pipe_d[1] <= mem[b_idx];
        end else begin
          pipe_v[0] <= 1'b1;
          pipe_d[0] <= mem[b_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && beat_go && !b_read) begin
      for (int i = 0; i < 4; i++)
        if (!sd.sd_dqm[i]) mem[b_idx][8*i +: 8] <= sd_data[8*i +: 8];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_dq
    assign sd_data[8*i +: 8] = out_oe[i] ? out_d[8*i +: 8] : 8'bz;
  end
endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed bench for sdram_responder: init, masking, CL3 bursts,
// tRCD and refresh violations, reset during a read.
module tb_sdram_responder;
  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] BT  = 3'b110;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] LMR = 3'b000;

  logic        clk = 1'b0;
  logic        reset;
  logic        tb_drv;
  logic [31:0] tb_wdata;
  wire  [31:0] sd_data;
  logic        init_done;
  logic        error;
  logic [2:0]  error_code;
  logic [15:0] refresh_cnt;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  sdram_responder_if sif();

  sdram_responder #(.MEM_AW(14), .TRCD(2), .TRFC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .sd          (sif),
    .sd_data     (sd_data),
    .init_done   (init_done),
    .error       (error),
    .error_code  (error_code),
    .refresh_cnt (refresh_cnt)
  );

  assign sd_data = tb_drv ? tb_wdata : 32'bz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] a,
                     input logic [3:0] dqm);
    sif.sd_cs   = (c == NOP);
    {sif.sd_ras, sif.sd_cas, sif.sd_we} = c;
    sif.sd_ba   = ba;
    sif.sd_addr = a;
    sif.sd_dqm  = dqm;
    tick();
    sif.sd_cs   = 1'b1;
    {sif.sd_ras, sif.sd_cas, sif.sd_we} = NOP;
    sif.sd_dqm  = 4'h0;
  endtask

  task automatic wr(input logic [1:0] ba, input logic [10:0] a, input logic [31:0] d,
                    input logic [3:0] dqm);
    tb_drv   = 1'b1;
    tb_wdata = d;
    cmd(WR, ba, a, dqm);
    tb_drv   = 1'b0;
  endtask

  task automatic nop_data(input logic [31:0] d);
    tb_drv   = 1'b1;
    tb_wdata = d;
    tick();
    tb_drv   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    tb_drv = 1'b0;
    tb_wdata = 32'd0;
    sif.sd_cke = 1'b1;
    sif.sd_cs = 1'b1;
    {sif.sd_ras, sif.sd_cas, sif.sd_we} = NOP;
    sif.sd_ba = 2'd0;
    sif.sd_addr = 11'd0;
    sif.sd_dqm = 4'h0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_error_code", 32'(error_code), 32'd0);
    chk("rst_refresh_cnt", 32'(refresh_cnt), 32'd0);
    chk("rst_bus_released", 32'(dut.out_oe), 32'd0);

    // init then single access (CL2, BL1, single-write)
    cmd(PRE, 2'd0, 11'h400, 4'h0);
    cmd(LMR, 2'd0, 11'h220, 4'h0);
    chk("init_done", 32'(init_done), 32'd1);
    cmd(ACT, 2'd1, 11'h155, 4'h0);
    tick();
    tick();
    wr(2'd1, 11'h412, 32'hDEADBEEF, 4'h0);
    cmd(ACT, 2'd1, 11'h155, 4'h0);
    tick();
    cmd(RD, 2'd1, 11'h412, 4'h0);
    chk("rd1_not_early", 32'(dut.out_oe), 32'd0);
    tick();
    chk("rd1_data", sd_data, 32'hDEADBEEF);
    chk("rd1_oe", 32'(dut.out_oe), 32'hF);
    tick();
    chk("rd1_released", 32'(dut.out_oe), 32'd0);
    chk("rd1_no_error", 32'(error), 32'd0);

    // byte-masked write, then back-to-back reads with a read DQM on the second
    cmd(ACT, 2'd1, 11'h155, 4'h0);
    tick();
    wr(2'd1, 11'h412, 32'h11223344, 4'b0111);
    cmd(ACT, 2'd1, 11'h155, 4'h0);
    tick();
    cmd(RD, 2'd1, 11'h012, 4'h0);
    cmd(RD, 2'd1, 11'h012, 4'b0010);
    chk("mask_data", sd_data, 32'h11ADBEEF);
    chk("mask_oe", 32'(dut.out_oe), 32'hF);
    tick();
    chk("rdqm_oe", 32'(dut.out_oe), 32'hD);
    chk("rdqm_data", sd_data & 32'hFFFF00FF, 32'h11AD00EF);
    tick();
    chk("rdqm_released", 32'(dut.out_oe), 32'd0);
    cmd(PRE, 2'd1, 11'h000, 4'h0);

    // CL3 BL4 burst write then wrapped burst read
    cmd(LMR, 2'd0, 11'h032, 4'h0);
    cmd(ACT, 2'd2, 11'h0AA, 4'h0);
    tick();
    wr(2'd2, 11'h006, 32'hC0DE0006, 4'h0);
    nop_data(32'hC0DE0007);
    nop_data(32'hC0DE0004);
    nop_data(32'hC0DE0005);
    cmd(RD, 2'd2, 11'h006, 4'h0);
    tick();
    chk("cl3_not_early", 32'(dut.out_oe), 32'd0);
    tick();
    chk("cl3_beat0", sd_data, 32'hC0DE0006);
    tick();
    chk("cl3_beat1", sd_data, 32'hC0DE0007);
    tick();
    chk("cl3_beat2", sd_data, 32'hC0DE0004);
    tick();
    chk("cl3_beat3", sd_data, 32'hC0DE0005);
    tick();
    chk("cl3_released", 32'(dut.out_oe), 32'd0);
    chk("cl3_no_error", 32'(error), 32'd0);

    // burst terminate: queued beat still appears, the rest are dropped
    cmd(RD, 2'd2, 11'h004, 4'h0);
    cmd(BT, 2'd0, 11'h000, 4'h0);
    tick();
    chk("bt_beat0", sd_data, 32'hC0DE0004);
    tick();
    chk("bt_stopped", 32'(dut.out_oe), 32'd0);

    // tRCD violation
    cmd(ACT, 2'd3, 11'h001, 4'h0);
    cmd(RD, 2'd3, 11'h000, 4'h0);
    chk("trcd_error", 32'(error), 32'd1);
    chk("trcd_code", 32'(error_code), 32'd3);

    // refresh busy violation, then legal gap after reset
    do_reset();
    cmd(REF, 2'd0, 11'h000, 4'h0);
    chk("ref_cnt1", 32'(refresh_cnt), 32'd1);
    tick();
    cmd(ACT, 2'd0, 11'h010, 4'h0);
    chk("trfc_error", 32'(error), 32'd1);
    chk("trfc_code", 32'(error_code), 32'd7);
    do_reset();
    chk("ref_cnt_reset", 32'(refresh_cnt), 32'd0);
    cmd(REF, 2'd0, 11'h000, 4'h0);
    repeat (4) tick();
    cmd(ACT, 2'd0, 11'h010, 4'h0);
    chk("trfc_gap_ok", 32'(error), 32'd0);
    chk("ref_cnt_gap", 32'(refresh_cnt), 32'd1);

    // reset during a CL2 read; array contents survive reset
    do_reset();
    cmd(ACT, 2'd1, 11'h155, 4'h0);
    tick();
    cmd(RD, 2'd1, 11'h412, 4'h0);
    reset = 1'b1;
    tick();
    chk("rstrd_released", 32'(dut.out_oe), 32'd0);
    tick();
    chk("rstrd_still_released", 32'(dut.out_oe), 32'd0);
    chk("rstrd_init_done", 32'(init_done), 32'd0);
    chk("rstrd_error", 32'(error), 32'd0);
    chk("rstrd_error_code", 32'(error_code), 32'd0);
    chk("rstrd_refresh_cnt", 32'(refresh_cnt), 32'd0);
    reset = 1'b0;
    cmd(ACT, 2'd1, 11'h155, 4'h0);
    tick();
    cmd(RD, 2'd1, 11'h012, 4'h0);
    tick();
    chk("mem_kept", sd_data, 32'h11ADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
# sdram_responder

Cycle-accurate responder model of the 32-bit SDR SDRAM seen by the Nano 20k SDRAM controller. It sits on the far side of the `sd_*` pins and decodes the command bus. It tracks open rows per bank and the mode register, stores write data, and returns read data at the programmed CAS latency. It also flags protocol violations, so controller benches run against a checking memory instead of a passive array.

## Interface

**Parameters**
- `MEM_AW`, default 14: word-address bits actually stored. Index is `{ba,row,col}` truncated to its low `MEM_AW` bits; higher addresses alias.
- `TRCD`, default 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- `TRFC`, default 4: cycles after AUTO_REFRESH during which only NOP is legal.

**Ports**
- `clk` in 1: SDRAM clock.
- `reset` in 1: synchronous, active-high.
- `sd_cke` in 1: clock enable. Low means the cycle is treated as NOP and all pipelines hold.
- `sd_cs` in 1: chip select, active low. High means NOP.
- `sd_ras`, `sd_cas`, `sd_we` in 1 each: command `{ras,cas,we}`.
- `sd_ba` in 2: bank.
- `sd_addr` in 11: row on ACTIVE; `{A10,col[7:0]}` on READ/WRITE; A10 selects all banks on PRECHARGE; opcode on LOAD_MODE.
- `sd_dqm` in 4: byte masks, high = masked; `[3]` maps to `sd_data[31:24]`.
- `sd_data` inout 32: data bus, driven only during read data beats.
- `init_done` out 1: PRECHARGE-all seen, followed by LOAD_MODE.
- `error` out 1: sticky, set on the first violation.
- `error_code` out 3: code of the first violation, frozen while `error` is set.
- `refresh_cnt` out 16: AUTO_REFRESH count, wraps at 0xFFFF→0.

## Operation

- Commands decoded (`{ras,cas,we}`): NOP 111, ACTIVE 011, READ 101, WRITE 100, BURST_TERMINATE 110, PRECHARGE 010, AUTO_REFRESH 001, LOAD_MODE 000.
- **Per-bank state:** IDLE / ACTIVE(row) / AUTOPRE(count). A per-bank tRCD counter is loaded with `TRCD-1` on ACTIVE.
- **ACTIVE:** IDLE→ACTIVE with the row latched. ACTIVE on a bank that is not IDLE is error 1.
- **PRECHARGE:** closes bank `ba`, or all banks when A10=1. Precharging an IDLE bank is legal.
- **READ/WRITE:**
  - Bank not in ACTIVE: error 2.
  - tRCD counter nonzero: error 3. The access is still performed.
  - A10=1 selects auto-precharge. The bank moves to AUTOPRE and returns to IDLE BL cycles after the command.
- **Mode register:** `addr[2:0]` = BL (000/001/010/011 → 1/2/4/8); `addr[3]` = interleaved; `addr[6:4]` = CL (2 or 3); `addr[9]` = single-write.
  - CL other than 2/3, BL code above 011, or interleaved=1: error 4. The register keeps its previous value.
  - LOAD_MODE while any bank is not IDLE: error 5.
- **Burst addressing:** beat address = `col` with its low `log2(BL)` bits incrementing and wrapping; the upper bits are fixed. Writes with single-write=1 use BL=1.
- **WRITE:** beat 0 is sampled with the command. Each byte is written only if its `sd_dqm` bit is 0 on that beat.
- **READ:** beats are queued into a CL-deep output pipeline.
  - DQM on reads has 2-cycle latency: a masked byte is tristated.
  - A new READ/WRITE truncates the running burst.
  - BURST_TERMINATE stops the remaining beats; on reads, queued beats already in the CL pipeline still appear.
- **AUTO_REFRESH:** `refresh_cnt`+1 and starts the tRFC busy counter.
  - Any bank not IDLE: error 6.
  - Any non-NOP command while busy: error 7, and the command is ignored.
- **Memory contents:** the array is not cleared by `reset`; the contents are X.

## Timing

- Sample edge E = the rising edge at which a command is seen with `sd_cs`=0 and `sd_cke`=1.
- **Read data:**
  - Beat k is valid at edge E+CL+k. It is driven from the clock edge before it and released after it, giving a 1-cycle drive window per beat.
  - Bus idle means high-Z.
- **Write data:** beat k is sampled at edge E+k.
- **Reset values:** all banks IDLE, mode = CL2/BL1/sequential/burst-write, `init_done`=0, `error`=0, `error_code`=0, `refresh_cnt`=0, `sd_data` high-Z.
- **Reset mid-burst:** the output is released on the cycle after the reset edge, and the pipelines are flushed.
- **Simultaneous events:** if two violations occur on the same edge, the lower code is latched. The CL pipeline continues to drain across PRECHARGE.

## Configuration

- `SDRAM_RESP_INIT_CHECK_EN` defined:
  - ACTIVE, READ, WRITE or AUTO_REFRESH before `init_done` is error 0b000 with `error`=1. The code is reported as 0 and is distinguishable by `error`.
  - The access is still executed.
- Not defined: commands are accepted immediately using the reset mode (CL2, BL1), and `init_done` is still reported.

## Test plan

- **Init then single access:** PRECHARGE A10=1, LOAD_MODE 0x220 (CL2, BL1, single-write), then ACTIVE ba=1 row=0x155, two NOPs, WRITE col 0x12 A10=1 data 0xDEADBEEF dqm 0000, then ACTIVE, READ at the same address → `init_done`=1, `sd_data`=0xDEADBEEF exactly 2 edges after READ, `error`=0.
- **Byte mask:** WRITE 0x11223344 with dqm 0111 over 0xDEADBEEF → readback 0x11ADBEEF.
- **Burst and CL3:** LOAD_MODE CL3 BL4, WRITE beats 0..3 at col 0x06 with single-write off → READ col 0x06 returns beats in order col 6, 7, 4, 5, starting at E+3.
- **tRCD violation:** ACTIVE then READ on the next edge → `error`=1, `error_code`=3.
- **Refresh:** AUTO_REFRESH, ACTIVE 2 cycles later → `refresh_cnt`=1, `error_code`=7. Repeat after reset with a 5-cycle gap → no error.
- **Reset mid-read:** assert `reset` at E+1 of a CL2 read → `sd_data` high-Z from the next cycle, all outputs at reset values.
